// File: rtl/div_issue_ctrl.sv
// Execute-stage front end for the shared iterative divider: issues, holds, times out and returns.
// Optional macro DIV_RESULT_CACHE_EN adds a one-entry result cache for DIV/MOD pairs.
module div_issue_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic [1:0]          op_i,
  input  logic [DATA_W-1:0]   src1_i,
  input  logic [DATA_W-1:0]   src2_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [DATA_W-1:0]   result_o,
  output logic                valid_o,
  output logic                timeout_o,
  output logic                div_start_o,
  output logic                div_cancel_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_done_i
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {StIdle, StBusy, StZero, StDone, StCancel} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rem_sel_q, rem_sel_d;
  logic                start_q, start_d;
  logic                cancel_q, cancel_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   div_sel;

  assign div_sel = rem_sel_q ? div_result_i[2*DATA_W-1:DATA_W] : div_result_i[DATA_W-1:0];

`ifdef DIV_RESULT_CACHE_EN
  logic                c_valid_q, c_valid_d;
  logic [DATA_W-1:0]   c_src1_q, c_src1_d;
  logic [DATA_W-1:0]   c_src2_q, c_src2_d;
  logic                c_signed_q, c_signed_d;
  logic [2*DATA_W-1:0] c_res_q, c_res_d;
  logic                cache_hit;

  assign cache_hit = c_valid_q && (src1_i == c_src1_q) && (src2_i == c_src2_q) &&
                     (~op_i[0] == c_signed_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid_q  <= 1'b0;
      c_src1_q   <= '0;
      c_src2_q   <= '0;
      c_signed_q <= 1'b0;
      c_res_q    <= '0;
    end else begin
      c_valid_q  <= c_valid_d;
      c_src1_q   <= c_src1_d;
      c_src2_q   <= c_src2_d;
      c_signed_q <= c_signed_d;
      c_res_q    <= c_res_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    start_d   = start_q;
    cancel_d  = 1'b0;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef DIV_RESULT_CACHE_EN
    c_valid_d  = c_valid_q;
    c_src1_d   = c_src1_q;
    c_src2_d   = c_src2_q;
    c_signed_d = c_signed_q;
    c_res_d    = c_res_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_i && !flush_i) begin
          if (src2_i == '0) begin
            state_d = StZero;
`ifdef DIV_RESULT_CACHE_EN
          end else if (cache_hit) begin
            state_d  = StDone;
            valid_d  = 1'b1;
            result_d = op_i[1] ? c_res_q[2*DATA_W-1:DATA_W] : c_res_q[DATA_W-1:0];
`endif
          end else begin
            state_d   = StBusy;
            cnt_d     = '0;
            rem_sel_d = op_i[1];
            start_d   = 1'b1;
            signed_d  = ~op_i[0];
            op1_d     = src1_i;
            op2_d     = src2_i;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CntW'(1);
        // Flush beats a same-cycle done; done beats a same-cycle timeout.
        if (flush_i) begin
          state_d  = StCancel;
          cancel_d = 1'b1;
          start_d  = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
          c_valid_d = 1'b0;
`endif
        end else if (div_done_i) begin
          state_d  = StDone;
          result_d = div_sel;
          valid_d  = 1'b1;
          start_d  = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
          c_valid_d  = 1'b1;
          c_src1_d   = op1_q;
          c_src2_d   = op2_q;
          c_signed_d = signed_q;
          c_res_d    = div_result_i;
`endif
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          result_d  = '0;
          valid_d   = 1'b1;
          start_d   = 1'b0;
          cancel_d  = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
          c_valid_d = 1'b0;
`endif
        end
      end
      StZero: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          result_d = '0;
          valid_d  = 1'b1;
        end
      end
      StDone:   state_d = StIdle;
      StCancel: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_o      = req_i && !flush_i &&
                        (state_q == StIdle || state_q == StBusy || state_q == StZero);
  assign result_o     = result_q;
  assign valid_o      = valid_q;
  assign timeout_o    = timeout_q;
  assign div_start_o  = start_q;
  assign div_cancel_o = cancel_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;

endmodule
